// File: rtl/pulse_checker_pkg.sv
// Shared FSM encodings and default parameters for the pulse checker.
package pulse_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_EXP_HIGH = 4;
    localparam int DEF_EXP_LOW  = 4;
    localparam int DEF_TOL      = 1;
    localparam int DEF_PULSES   = 2;

    // Lower acceptance bound, clamped to 1 so a small expectation never wraps.
    function automatic int lower_bound(input int exp_v, input int tol);
        return (exp_v - tol < 1) ? 1 : exp_v - tol;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rise/fall strobes on the synchronized level.
module sync_edge
    import pulse_checker_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic signal,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = signal;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/pulse_checker.sv
// Measures high/low phases of a pulse train and flags bursts of valid pulses.
module pulse_checker
    import pulse_checker_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int EXP_HIGH = DEF_EXP_HIGH,
    parameter int EXP_LOW  = DEF_EXP_LOW,
    parameter int TOL      = DEF_TOL,
    parameter int PULSES   = DEF_PULSES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    input  logic             enable,
    output logic             match,
    output logic             error,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] width,
    output logic             busy
);

    localparam logic [WIDTH-1:0] HI_MIN  = WIDTH'(lower_bound(EXP_HIGH, TOL));
    localparam logic [WIDTH-1:0] HI_MAX  = WIDTH'(EXP_HIGH + TOL);
    localparam logic [WIDTH-1:0] LO_MIN  = WIDTH'(lower_bound(EXP_LOW, TOL));
    localparam logic [WIDTH-1:0] LO_MAX  = WIDTH'(EXP_LOW + TOL);
    localparam logic [WIDTH-1:0] NPULSE  = WIDTH'(PULSES);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic s_level, s_rise, s_fall;

    sync_edge u_sync (
        .clock  (clock),
        .reset  (reset),
        .signal (signal),
        .level  (s_level),
        .rise   (s_rise),
        .fall   (s_fall)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] width_q, width_d;
    logic             match_q, match_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] count_inc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        width_d   = width_q;
        match_d   = 1'b0;
        error_d   = 1'b0;
        count_inc = count_q + ONE;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_rise) begin
                        state_d = HIGH;
                        cnt_d   = ONE;
                    end
                end
                HIGH: begin
                    if (s_fall) begin
                        width_d = cnt_q;
                        if (cnt_q < HI_MIN || cnt_q > HI_MAX) begin
                            error_d = 1'b1;
                            count_d = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else if (count_inc == NPULSE) begin
                            match_d = 1'b1;
                            count_d = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            count_d = count_inc;
                            cnt_d   = ONE;
                            state_d = LOW;
                        end
                    end else if (s_level && cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                LOW: begin
                    // Timeout fires when the count would step past the upper bound.
                    if (s_rise ? (cnt_q < LO_MIN || cnt_q > LO_MAX)
                               : (cnt_q >= LO_MAX)) begin
                        error_d = 1'b1;
                        count_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (s_rise) begin
                        cnt_d   = ONE;
                        state_d = HIGH;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            width_q <= '0;
            match_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            width_q <= width_d;
            match_q <= match_d;
            error_q <= error_d;
        end
    end

    assign match = match_q;
    assign error = error_q;
    assign count = count_q;
    assign width = width_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_checker.sv
// Directed and randomized checks of pulse_checker against a run-length model.
module tb_pulse_checker;

    localparam int W    = 8;
    localparam int EH   = 4;
    localparam int EL   = 4;
    localparam int TOL  = 1;
    localparam int NP   = 2;
    localparam int HMIN = (EH - TOL < 1) ? 1 : EH - TOL;
    localparam int HMAX = EH + TOL;
    localparam int LMIN = (EL - TOL < 1) ? 1 : EL - TOL;
    localparam int LMAX = EL + TOL;
    localparam int MAXN = 256;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         signal = 1'b0;
    logic         enable = 1'b1;
    logic         match, error, busy;
    logic [W-1:0] count, width;

    int checks   = 0;
    int failures = 0;

    int n;
    int r  [MAXN];
    int en [MAXN];

    logic         om [MAXN];
    logic         oe [MAXN];
    logic         ob [MAXN];
    logic [W-1:0] oc [MAXN];
    logic [W-1:0] ow [MAXN];

    logic         em [MAXN];
    logic         ee [MAXN];
    logic         eb [MAXN];
    logic [W-1:0] ec [MAXN];
    logic [W-1:0] ew [MAXN];
    int sb [MAXN];
    int sc [MAXN];
    int sw [MAXN];

    pulse_checker #(
        .WIDTH    (W),
        .EXP_HIGH (EH),
        .EXP_LOW  (EL),
        .TOL      (TOL),
        .PULSES   (NP)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .signal (signal),
        .enable (enable),
        .match  (match),
        .error  (error),
        .count  (count),
        .width  (width),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset  = 1'b0;
        signal = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic add(input int level, input int len);
        for (int i = 0; i < len; i++) begin
            if (n < MAXN) begin
                r[n]  = level;
                en[n] = 1;
                n++;
            end
        end
    endtask

    // Raw sample j is taken at posedge j; outputs recorded 1ns later.
    task automatic play();
        for (int j = 0; j < n; j++) begin
            @(negedge clock);
            signal = (r[j] != 0);
            enable = (en[j] != 0);
            @(posedge clock);
            #1;
            om[j] = match;
            oe[j] = error;
            ob[j] = busy;
            oc[j] = count;
            ow[j] = width;
        end
        @(negedge clock);
        signal = 1'b0;
        enable = 1'b1;
    endtask

    function automatic int sum_m();
        int s = 0;
        for (int i = 0; i < n; i++) if (om[i] === 1'b1) s++;
        return s;
    endfunction

    function automatic int sum_e();
        int s = 0;
        for (int i = 0; i < n; i++) if (oe[i] === 1'b1) s++;
        return s;
    endfunction

    function automatic int find_rise(input int from);
        for (int i = from; i < n; i++)
            if (i > 0 && r[i] != 0 && r[i-1] == 0) return i;
        return n;
    endfunction

    function automatic int find_fall(input int from);
        for (int i = from + 1; i < n; i++)
            if (r[i] == 0 && r[i-1] != 0) return i;
        return n;
    endfunction

    // kind: 0 match, 1 error, 2 busy level, 3 count value, 4 width value
    task automatic ev(input int t, input int kind, input int val);
        if (t < n) begin
            case (kind)
                0: em[t] = 1'b1;
                1: ee[t] = 1'b1;
                2: sb[t] = val;
                3: sc[t] = val;
                default: sw[t] = val;
            endcase
        end
    endtask

    task automatic burst_end(input int t, input int kind);
        ev(t, kind, 1);
        ev(t, 3, 0);
        ev(t, 2, 0);
    endtask

    // Walks the raw run lengths; a raw transition at k is acted on at posedge k+2.
    task automatic run_model();
        int k, f, h, l, nr, c, cb, cc, cw;
        bit done;
        for (int i = 0; i < MAXN; i++) begin
            em[i] = 1'b0;
            ee[i] = 1'b0;
            sb[i] = -1;
            sc[i] = -1;
            sw[i] = -1;
        end
        c = 0;
        k = find_rise(0);
        while (k < n) begin
            ev(k + 2, 2, 1);
            done = 1'b0;
            while (!done) begin
                f = find_fall(k);
                if (f >= n) begin
                    k = n;
                    done = 1'b1;
                end else begin
                    h = f - k;
                    ev(f + 2, 4, h);
                    if (h < HMIN || h > HMAX) begin
                        c = 0;
                        burst_end(f + 2, 1);
                        k = find_rise(f);
                        done = 1'b1;
                    end else if (c + 1 == NP) begin
                        c = 0;
                        burst_end(f + 2, 0);
                        k = find_rise(f);
                        done = 1'b1;
                    end else begin
                        c++;
                        ev(f + 2, 3, c);
                        nr = find_rise(f);
                        l  = nr - f;
                        if (l > LMAX) begin
                            c = 0;
                            burst_end(f + 2 + LMAX, 1);
                            k = nr;
                            done = 1'b1;
                        end else if (nr >= n) begin
                            k = n;
                            done = 1'b1;
                        end else if (l < LMIN) begin
                            c = 0;
                            burst_end(nr + 2, 1);
                            k = find_rise(nr + 1);
                            done = 1'b1;
                        end else begin
                            k = nr;
                        end
                    end
                end
            end
        end
        cb = 0;
        cc = 0;
        cw = 0;
        for (int i = 0; i < n; i++) begin
            if (sb[i] >= 0) cb = sb[i];
            if (sc[i] >= 0) cc = sc[i];
            if (sw[i] >= 0) cw = sw[i];
            eb[i] = (cb != 0);
            ec[i] = W'(cc);
            ew[i] = W'(cw);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        signal = 1'b1;
        enable = 1'b1;
        #12;
        checks++;
        if ({match, error, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=000", {match, error, busy});
        end
        checks++;
        if ({count, width} !== '0) begin
            failures++;
            $display("FAIL reset_regs count=%0d width=%0d want=0", count, width);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        n = 0;
        add(0, 3); add(1, 4); add(0, 4); add(1, 4); add(0, 12);
        play();
        checks++;
        if (om[17] !== 1'b1) begin
            failures++;
            $display("FAIL basic_match_time got=%b want=1", om[17]);
        end
        checks++;
        if (sum_m() != 1 || sum_e() != 0) begin
            failures++;
            $display("FAIL basic_strobes matches=%0d errors=%0d want=1,0", sum_m(), sum_e());
        end
        checks++;
        if (oc[12] !== 8'd1 || ob[16] !== 1'b1) begin
            failures++;
            $display("FAIL basic_mid count=%0d busy=%b want=1,1", oc[12], ob[16]);
        end
        checks++;
        if (ow[n-1] !== 8'd4 || ob[17] !== 1'b0 || oc[17] !== 8'd0) begin
            failures++;
            $display("FAIL basic_end width=%0d busy=%b count=%0d want=4,0,0",
                     ow[n-1], ob[17], oc[17]);
        end
    endtask

    task automatic test_wide();
        do_reset();
        n = 0;
        add(0, 3); add(1, 7); add(0, 10);
        play();
        checks++;
        if (oe[12] !== 1'b1 || oe[11] !== 1'b0) begin
            failures++;
            $display("FAIL wide_error got=%b%b want=01", oe[11], oe[12]);
        end
        checks++;
        if (ow[12] !== 8'd7 || oc[12] !== 8'd0 || sum_m() != 0 || sum_e() != 1) begin
            failures++;
            $display("FAIL wide_state width=%0d count=%0d m=%0d e=%0d want=7,0,0,1",
                     ow[12], oc[12], sum_m(), sum_e());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        n = 0;
        add(0, 3); add(1, 4); add(0, 14);
        play();
        checks++;
        if (oe[14] !== 1'b1 || sum_e() != 1 || sum_m() != 0) begin
            failures++;
            $display("FAIL timeout_error got=%b e=%0d m=%0d want=1,1,0",
                     oe[14], sum_e(), sum_m());
        end
        checks++;
        if (ob[13] !== 1'b1 || ob[14] !== 1'b0 || oc[14] !== 8'd0) begin
            failures++;
            $display("FAIL timeout_busy got=%b%b count=%0d want=10,0",
                     ob[13], ob[14], oc[14]);
        end
    endtask

    task automatic test_tolerance();
        do_reset();
        n = 0;
        add(0, 3); add(1, 3); add(0, 4); add(1, 5); add(0, 8);
        play();
        checks++;
        if (om[17] !== 1'b1 || sum_e() != 0 || ow[n-1] !== 8'd5) begin
            failures++;
            $display("FAIL tol_3_5 match=%b e=%0d width=%0d want=1,0,5",
                     om[17], sum_e(), ow[n-1]);
        end
        do_reset();
        n = 0;
        add(0, 3); add(1, 2); add(0, 10);
        play();
        checks++;
        if (oe[7] !== 1'b1 || ow[7] !== 8'd2 || sum_m() != 0) begin
            failures++;
            $display("FAIL tol_2 err=%b width=%0d m=%0d want=1,2,0", oe[7], ow[7], sum_m());
        end
        do_reset();
        n = 0;
        add(0, 3); add(1, 6); add(0, 10);
        play();
        checks++;
        if (oe[11] !== 1'b1 || ow[11] !== 8'd6 || sum_m() != 0) begin
            failures++;
            $display("FAIL tol_6 err=%b width=%0d m=%0d want=1,6,0", oe[11], ow[11], sum_m());
        end
    endtask

    task automatic test_toggle();
        do_reset();
        n = 0;
        add(0, 3);
        for (int i = 0; i < 10; i++) begin
            add(1, 1);
            add(0, 1);
        end
        add(0, 4);
        play();
        checks++;
        if (oe[6] !== 1'b1 || oe[5] !== 1'b0 || ow[6] !== 8'd1 || sum_m() != 0) begin
            failures++;
            $display("FAIL toggle err=%b%b width=%0d m=%0d want=01,1,0",
                     oe[5], oe[6], ow[6], sum_m());
        end
    endtask

    task automatic test_enable();
        do_reset();
        n = 0;
        add(0, 3); add(1, 4); add(0, 4); add(1, 4);
        add(0, 5); add(1, 4); add(0, 4); add(1, 4); add(0, 6);
        en[14] = 0;
        en[15] = 0;
        play();
        checks++;
        if (ob[13] !== 1'b1 || oc[13] !== 8'd1) begin
            failures++;
            $display("FAIL en_before busy=%b count=%0d want=1,1", ob[13], oc[13]);
        end
        checks++;
        if (ob[14] !== 1'b0 || oc[14] !== 8'd0 || ow[14] !== 8'd4) begin
            failures++;
            $display("FAIL en_abort busy=%b count=%0d width=%0d want=0,0,4",
                     ob[14], oc[14], ow[14]);
        end
        checks++;
        if (om[34] !== 1'b1 || sum_m() != 1 || sum_e() != 0) begin
            failures++;
            $display("FAIL en_after match=%b m=%0d e=%0d want=1,1,0", om[34], sum_m(), sum_e());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        n = 0;
        add(0, 3); add(1, 4); add(0, 4);
        play();
        checks++;
        if (busy !== 1'b1 || count !== 8'd1 || width !== 8'd4) begin
            failures++;
            $display("FAIL rmid_pre busy=%b count=%0d width=%0d want=1,1,4", busy, count, width);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({match, error, busy} !== 3'b000 || count !== '0 || width !== '0) begin
            failures++;
            $display("FAIL rmid_async flags=%b count=%0d width=%0d want=000,0,0",
                     {match, error, busy}, count, width);
        end
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        add(0, 10); add(1, 4); add(0, 4); add(1, 4); add(0, 6);
        play();
        checks++;
        if (om[24] !== 1'b1 || sum_m() != 1 || sum_e() != 0) begin
            failures++;
            $display("FAIL rmid_after match=%b m=%0d e=%0d want=1,1,0", om[24], sum_m(), sum_e());
        end
    endtask

    task automatic test_random();
        int hl, ll;
        for (int it = 0; it < 12; it++) begin
            do_reset();
            n = 0;
            add(0, 3);
            while (n < 150) begin
                hl = ($urandom_range(0, 1) != 0) ? int'($urandom_range(HMIN, HMAX))
                                                 : int'($urandom_range(1, 7));
                ll = ($urandom_range(0, 1) != 0) ? int'($urandom_range(LMIN, LMAX))
                                                 : int'($urandom_range(1, 8));
                add(1, hl);
                add(0, ll);
            end
            add(0, 8);
            play();
            run_model();
            for (int i = 0; i < n; i++) begin
                checks++;
                if ({om[i], oe[i]} !== {em[i], ee[i]}) begin
                    failures++;
                    if (failures < 40)
                        $display("FAIL rand_strobe it=%0d cyc=%0d got=%b%b want=%b%b",
                                 it, i, om[i], oe[i], em[i], ee[i]);
                end
                checks++;
                if (ob[i] !== eb[i] || oc[i] !== ec[i]) begin
                    failures++;
                    if (failures < 40)
                        $display("FAIL rand_state it=%0d cyc=%0d busy=%b count=%0d want=%b,%0d",
                                 it, i, ob[i], oc[i], eb[i], ec[i]);
                end
                checks++;
                if (ow[i] !== ew[i]) begin
                    failures++;
                    if (failures < 40)
                        $display("FAIL rand_width it=%0d cyc=%0d got=%0d want=%0d",
                                 it, i, ow[i], ew[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_timeout();
        test_tolerance();
        test_toggle();
        test_enable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
